// File: rtl/soc_system_pio_arbiter.sv
// Three-requester round-robin arbiter in front of a single PIO slave.
// Each accepted request becomes one PIO bus cycle (ISSUE); reads take one
// extra cycle (CAPTURE) to pick up the slave's registered read data. The
// owner of the transfer then gets a one-cycle rsp_valid pulse.
module soc_system_pio_arbiter #(
  parameter int DATA_W = 32,
  parameter int NREQ   = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_write,
  input  logic [2*NREQ-1:0]      req_address,
  input  logic [NREQ*DATA_W-1:0] req_writedata,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_readdata,
  output logic [1:0]             m_address,
  output logic                   m_chipselect,
  output logic                   m_write_n,
  output logic [DATA_W-1:0]      m_writedata,
  input  logic [DATA_W-1:0]      m_readdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        last_grant_q;
  logic [1:0]        owner_q;
  logic              write_q;
  logic [1:0]        grant_idx;
  logic [1:0]        cand;
  logic              grant_any;
  logic              accept;
  logic [1:0]        addr_arr  [NREQ];
  logic [DATA_W-1:0] wdata_arr [NREQ];

  // Split the flat per-requester buses into indexable arrays.
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_address[2*i +: 2];
    assign wdata_arr[i] = req_writedata[i*DATA_W +: DATA_W];
  end

  // Round-robin pick: first valid requester after last_grant, wrapping.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = 2'((int'(last_grant_q) + k) % NREQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Next-state logic and the combinational one-hot grant.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        // Gating with reset_n keeps req_ready low for the whole reset.
        if (reset_n && grant_any) begin
          req_ready[grant_idx] = 1'b1;
          accept               = 1'b1;
          state_d              = ISSUE;
        end
      end
      ISSUE:   state_d = write_q ? IDLE : CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any transfer in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of block order.
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Arbitration history and transfer ownership, captured on acceptance.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant_q <= 2'd2;
      owner_q      <= 2'd0;
      write_q      <= 1'b0;
    end else if (accept) begin
      last_grant_q <= grant_idx;
      owner_q      <= grant_idx;
      write_q      <= req_write[grant_idx];
    end
  end

  // PIO bus: strobes are high only for the ISSUE cycle, address and data
  // double as the latched request and hold until the next acceptance.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_address    <= '0;
      m_writedata  <= '0;
    end else begin
      m_chipselect <= accept;
      m_write_n    <= accept ? ~req_write[grant_idx] : 1'b1;
      if (accept) begin
        m_address   <= addr_arr[grant_idx];
        m_writedata <= wdata_arr[grant_idx];
      end
    end
  end

  // Completion: writes finish after ISSUE, reads after CAPTURE with data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rsp_valid    <= '0;
      rsp_readdata <= '0;
    end else begin
      rsp_valid <= '0;
      if (state_q == ISSUE && write_q) begin
        rsp_valid[owner_q] <= 1'b1;
      end
      if (state_q == CAPTURE) begin
        rsp_valid[owner_q] <= 1'b1;
        rsp_readdata       <= m_readdata;
      end
    end
  end

endmodule
